// File: rtl/hsi_band_streamer.sv
// rtl/hsi_band_streamer.sv - loads interleaved A/B element pairs into the HSI vector core FIFOs and supervises the run
//
// Purpose: on an accepted start, steer num_bands A/B element pairs from the input
// stream into the vector-A / vector-B FIFOs, launch the core, then wait for its
// completion (or a timeout) and report a one-cycle pixel_done with a held code.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   start_i, num_bands_i         start pulse and band count from the wrapper
//   s_valid_i, s_data_i, s_ready_o   input element stream (A0,B0,A1,B1,...)
//   fifo_a_wr_o, fifo_b_wr_o     write strobes into the vector-A / vector-B FIFOs
//   fifo_wdata_o                 shared FIFO write data (passthrough of s_data_i)
//   fifo_a_full_i, fifo_b_full_i FIFO full flags
//   core_start_o                 one-cycle core launch pulse
//   core_done_i, core_err_i      core completion pulse and its error code
//   pixel_done_o, error_code_o   completion pulse and held result code
//   busy_o                       high whenever not idle
module hsi_band_streamer #(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_BANDS_WIDTH = 8,
  parameter int ERR_WIDTH       = 8,
  parameter int TIMEOUT_WIDTH   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [NUM_BANDS_WIDTH-1:0] num_bands_i,
  input  logic                       s_valid_i,
  input  logic [DATA_WIDTH-1:0]      s_data_i,
  output logic                       s_ready_o,
  output logic                       fifo_a_wr_o,
  output logic                       fifo_b_wr_o,
  output logic [DATA_WIDTH-1:0]      fifo_wdata_o,
  input  logic                       fifo_a_full_i,
  input  logic                       fifo_b_full_i,
  output logic                       core_start_o,
  input  logic                       core_done_i,
  input  logic [ERR_WIDTH-1:0]       core_err_i,
  output logic                       pixel_done_o,
  output logic [ERR_WIDTH-1:0]       error_code_o,
  output logic                       busy_o
);

  localparam logic [ERR_WIDTH-1:0] ERR_NONE       = '0;
  localparam logic [ERR_WIDTH-1:0] ERR_ZERO_BANDS = ERR_WIDTH'(8'h01);
  localparam logic [ERR_WIDTH-1:0] ERR_TIMEOUT    = ERR_WIDTH'(8'hFF);

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_WAIT_CORE = 2'd2,
    S_DONE      = 2'd3
  } state_e;

  state_e                     state_q;
  logic [NUM_BANDS_WIDTH-1:0] nb_q;
  logic [NUM_BANDS_WIDTH-1:0] band_cnt_q;
  logic                       sel_q;
  logic [TIMEOUT_WIDTH-1:0]   tmo_q;
  logic [ERR_WIDTH-1:0]       err_q;

  logic load_s;
  logic hs_s;
  logic last_pair_s;

  assign load_s = (state_q == S_LOAD);

  // Ready follows the full flag of whichever FIFO the next element is destined for.
  assign s_ready_o    = load_s && ((sel_q == SEL_B) ? !fifo_b_full_i : !fifo_a_full_i);
  assign hs_s         = s_valid_i && s_ready_o;
  assign fifo_a_wr_o  = hs_s && (sel_q == SEL_A);
  assign fifo_b_wr_o  = hs_s && (sel_q == SEL_B);
  assign fifo_wdata_o = s_data_i;

  assign last_pair_s  = (band_cnt_q == nb_q - NUM_BANDS_WIDTH'(1));

  // The timeout counter is zero only in the first WAIT_CORE cycle (it never wraps
  // inside WAIT_CORE), so that cycle doubles as the core launch cycle.
  assign core_start_o = (state_q == S_WAIT_CORE) && (tmo_q == '0);
  assign pixel_done_o = (state_q == S_DONE);
  assign busy_o       = (state_q != S_IDLE);
  assign error_code_o = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      nb_q       <= '0;
      band_cnt_q <= '0;
      sel_q      <= SEL_A;
      tmo_q      <= '0;
      err_q      <= ERR_NONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (num_bands_i == '0) begin
              err_q   <= ERR_ZERO_BANDS;
              state_q <= S_DONE;
            end else begin
              nb_q       <= num_bands_i;
              band_cnt_q <= '0;
              sel_q      <= SEL_A;
              err_q      <= ERR_NONE;
              state_q    <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (hs_s) begin
            sel_q <= ~sel_q;
            if (sel_q == SEL_B) begin
              // band_cnt can reach nb (up to all-ones) but is never used past that point.
              band_cnt_q <= band_cnt_q + NUM_BANDS_WIDTH'(1);
              if (last_pair_s) begin
                tmo_q   <= '0;
                state_q <= S_WAIT_CORE;
              end
            end
          end
        end

        S_WAIT_CORE: begin
          // Completion takes priority over a coincident timeout.
          if (core_done_i) begin
            err_q   <= core_err_i;
            state_q <= S_DONE;
          end else if (tmo_q == '1) begin
            err_q   <= ERR_TIMEOUT;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
          end
        end

        S_DONE: begin
          tmo_q   <= '0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsi_band_streamer.sv
// tb/tb_hsi_band_streamer.sv - scoreboard bench for hsi_band_streamer
module tb_hsi_band_streamer;

  localparam int DW  = 16;
  localparam int NBW = 8;
  localparam int EW  = 8;
  localparam int TW  = 4;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic [NBW-1:0] num_bands_i;
  logic           s_valid_i;
  logic [DW-1:0]  s_data_i;
  logic           s_ready_o;
  logic           fifo_a_wr_o;
  logic           fifo_b_wr_o;
  logic [DW-1:0]  fifo_wdata_o;
  logic           fifo_a_full_i;
  logic           fifo_b_full_i;
  logic           core_start_o;
  logic           core_done_i;
  logic [EW-1:0]  core_err_i;
  logic           pixel_done_o;
  logic [EW-1:0]  error_code_o;
  logic           busy_o;

  hsi_band_streamer #(
    .DATA_WIDTH     (DW),
    .NUM_BANDS_WIDTH(NBW),
    .ERR_WIDTH      (EW),
    .TIMEOUT_WIDTH  (TW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .num_bands_i  (num_bands_i),
    .s_valid_i    (s_valid_i),
    .s_data_i     (s_data_i),
    .s_ready_o    (s_ready_o),
    .fifo_a_wr_o  (fifo_a_wr_o),
    .fifo_b_wr_o  (fifo_b_wr_o),
    .fifo_wdata_o (fifo_wdata_o),
    .fifo_a_full_i(fifo_a_full_i),
    .fifo_b_full_i(fifo_b_full_i),
    .core_start_o (core_start_o),
    .core_done_i  (core_done_i),
    .core_err_i   (core_err_i),
    .pixel_done_o (pixel_done_o),
    .error_code_o (error_code_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_cs, n_pd, cs_cyc, pd_cyc, start_cyc, both_wr;
  logic [EW-1:0] pd_err;
  logic hs;

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  logic [DW-1:0] obs_a[$];
  logic [DW-1:0] obs_b[$];

  // One clock: sample outputs at the falling edge, return 1 ns after the rising edge.
  task automatic tick();
    @(negedge clk_i);
    if (fifo_a_wr_o) obs_a.push_back(fifo_wdata_o);
    if (fifo_b_wr_o) obs_b.push_back(fifo_wdata_o);
    if (fifo_a_wr_o && fifo_b_wr_o) both_wr++;
    if (core_start_o) begin n_cs++; cs_cyc = cyc; end
    if (pixel_done_o) begin n_pd++; pd_cyc = cyc; pd_err = error_code_o; end
    hs = s_valid_i && s_ready_o;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic clear_counts();
    n_cs = 0; n_pd = 0; both_wr = 0; cs_cyc = -1; pd_cyc = -1; pd_err = '0;
  endtask

  function automatic int sb_mismatch();
    int m = 0;
    if (exp_a.size() != obs_a.size()) m++;
    if (exp_b.size() != obs_b.size()) m++;
    for (int k = 0; k < exp_a.size() && k < obs_a.size(); k++) if (exp_a[k] !== obs_a[k]) m++;
    for (int k = 0; k < exp_b.size() && k < obs_b.size(); k++) if (exp_b[k] !== obs_b[k]) m++;
    exp_a.delete(); exp_b.delete(); obs_a.delete(); obs_b.delete();
    return m;
  endfunction

  task automatic do_start(input int nb);
    start_i = 1'b1;
    num_bands_i = NBW'(nb);
    start_cyc = cyc;
    tick();
    start_i = 1'b0;
    num_bands_i = '0;
  endtask

  // Streams n elements base, base+1, ...; even index goes to A, odd to B.
  // The B FIFO reports full for bstall cycles while a B element is pending.
  task automatic feed(input int n, input int base, input int bstall);
    int i = 0;
    int pushed = -1;
    int guard = 0;
    int stall = bstall;
    while (i < n && guard < 200) begin
      s_valid_i = 1'b1;
      s_data_i = DW'(base + i);
      if (i != pushed) begin
        if (i % 2 == 0) exp_a.push_back(s_data_i);
        else exp_b.push_back(s_data_i);
        pushed = i;
      end
      fifo_b_full_i = (stall > 0) && (i % 2 == 1);
      tick();
      if (fifo_b_full_i) begin
        stall--;
        checks++;
        if (hs !== 1'b0) begin
          errors++;
          $display("FAIL stall_handshake: got %b, required 0", hs);
        end
      end else if (hs) begin
        i++;
      end
      guard++;
    end
    s_valid_i = 1'b0;
    fifo_b_full_i = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL feed_budget: accepted %0d elements, required %0d", i, n);
    end
  endtask

  task automatic wait_pd(input int budget);
    int g = 0;
    int n0 = n_pd;
    while (n_pd == n0 && g < budget) begin
      tick();
      g++;
    end
    checks++;
    if (n_pd == n0) begin
      errors++;
      $display("FAIL wait_pixel_done: no pulse within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i = 16'hABCD;
    tick();
    tick();
    #1;
    checks++;
    if ({s_ready_o, fifo_a_wr_o, fifo_b_wr_o, core_start_o, pixel_done_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 000000",
               {s_ready_o, fifo_a_wr_o, fifo_b_wr_o, core_start_o, pixel_done_o, busy_o});
    end
    checks++;
    if (error_code_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_err: got %h, required 00", error_code_o);
    end
    checks++;
    if (fifo_wdata_o !== 16'hABCD) begin
      errors++;
      $display("FAIL reset_wdata: got %h, required abcd", fifo_wdata_o);
    end
    s_valid_i = 1'b0;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_zero_bands();
    clear_counts();
    s_valid_i = 1'b1;
    do_start(0);
    tick();
    tick();
    s_valid_i = 1'b0;
    checks++;
    if (pd_cyc != start_cyc + 1 || n_pd != 1) begin
      errors++;
      $display("FAIL zero_pd_timing: pulses %0d at offset %0d, required 1 at 1", n_pd, pd_cyc - start_cyc);
    end
    checks++;
    if (pd_err !== 8'h01) begin
      errors++;
      $display("FAIL zero_code: got %h, required 01", pd_err);
    end
    checks++;
    if (n_cs != 0 || obs_a.size() != 0 || obs_b.size() != 0) begin
      errors++;
      $display("FAIL zero_side_effects: core_start %0d writes %0d/%0d, required 0 0/0",
               n_cs, obs_a.size(), obs_b.size());
    end
    checks++;
    if (error_code_o !== 8'h01) begin
      errors++;
      $display("FAIL zero_code_held: got %h, required 01", error_code_o);
    end
    void'(sb_mismatch());
  endtask

  task automatic test_basic();
    int m;
    clear_counts();
    do_start(4);
    feed(8, 1, 0);
    core_done_i = 1'b1;
    core_err_i = 8'h00;
    tick();
    core_done_i = 1'b0;
    tick();
    tick();
    checks++;
    if (n_cs != 1 || cs_cyc - start_cyc != 9) begin
      errors++;
      $display("FAIL basic_core_start: pulses %0d at offset %0d, required 1 at 9", n_cs, cs_cyc - start_cyc);
    end
    checks++;
    if (n_pd != 1 || pd_cyc != cs_cyc + 1) begin
      errors++;
      $display("FAIL basic_pixel_done: pulses %0d at offset %0d, required 1 at 1", n_pd, pd_cyc - cs_cyc);
    end
    checks++;
    if (pd_err !== 8'h00) begin
      errors++;
      $display("FAIL basic_code: got %h, required 00", pd_err);
    end
    checks++;
    if (obs_a.size() != 4 || obs_b.size() != 4 || both_wr != 0) begin
      errors++;
      $display("FAIL basic_write_count: A %0d B %0d both %0d, required 4 4 0", obs_a.size(), obs_b.size(), both_wr);
    end
    m = sb_mismatch();
    checks++;
    if (m != 0) begin
      errors++;
      $display("FAIL basic_scoreboard: %0d mismatches, required 0", m);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy %b, required 0", busy_o);
    end
  endtask

  task automatic test_b_full_stall();
    int m;
    clear_counts();
    do_start(3);
    feed(6, 16'h10, 5);
    core_done_i = 1'b1;
    core_err_i = 8'h2A;
    tick();
    core_done_i = 1'b0;
    tick();
    tick();
    checks++;
    if (obs_a.size() != 3 || obs_b.size() != 3 || both_wr != 0) begin
      errors++;
      $display("FAIL stall_write_count: A %0d B %0d both %0d, required 3 3 0", obs_a.size(), obs_b.size(), both_wr);
    end
    m = sb_mismatch();
    checks++;
    if (m != 0) begin
      errors++;
      $display("FAIL stall_scoreboard: %0d mismatches, required 0", m);
    end
    checks++;
    if (n_pd != 1 || pd_err !== 8'h2A) begin
      errors++;
      $display("FAIL stall_done: pulses %0d code %h, required 1 2a", n_pd, pd_err);
    end
  endtask

  task automatic test_timeout();
    clear_counts();
    do_start(1);
    feed(2, 16'h30, 0);
    wait_pd(40);
    tick();
    checks++;
    if (pd_cyc - cs_cyc != 16 || pd_err !== 8'hFF) begin
      errors++;
      $display("FAIL timeout_fire: offset %0d code %h, required 16 ff", pd_cyc - cs_cyc, pd_err);
    end
    void'(sb_mismatch());

    clear_counts();
    do_start(1);
    feed(2, 16'h32, 0);
    repeat (15) tick();
    core_done_i = 1'b1;
    core_err_i = 8'h05;
    tick();
    core_done_i = 1'b0;
    tick();
    tick();
    checks++;
    if (n_pd != 1 || pd_cyc - cs_cyc != 16 || pd_err !== 8'h05) begin
      errors++;
      $display("FAIL timeout_done_wins: pulses %0d offset %0d code %h, required 1 16 05",
               n_pd, pd_cyc - cs_cyc, pd_err);
    end
    void'(sb_mismatch());
  endtask

  task automatic test_ignored_start();
    int m;
    clear_counts();
    do_start(2);
    feed(2, 16'h60, 0);
    start_i = 1'b1;
    num_bands_i = 8'd7;
    tick();
    start_i = 1'b0;
    num_bands_i = '0;
    feed(2, 16'h62, 0);
    start_i = 1'b1;
    num_bands_i = 8'd3;
    tick();
    start_i = 1'b0;
    num_bands_i = '0;
    tick();
    tick();
    checks++;
    if (error_code_o !== 8'h00 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL ignored_start_state: code %h busy %b, required 00 1", error_code_o, busy_o);
    end
    core_done_i = 1'b1;
    core_err_i = 8'h33;
    tick();
    core_done_i = 1'b0;
    repeat (8) tick();
    checks++;
    if (n_cs != 1 || n_pd != 1 || pd_err !== 8'h33) begin
      errors++;
      $display("FAIL ignored_start_run: core_start %0d pixel_done %0d code %h, required 1 1 33", n_cs, n_pd, pd_err);
    end
    m = sb_mismatch();
    checks++;
    if (m != 0) begin
      errors++;
      $display("FAIL ignored_start_scoreboard: %0d mismatches, required 0", m);
    end
  endtask

  task automatic test_reset_mid_load();
    int m;
    clear_counts();
    do_start(4);
    feed(3, 16'h40, 0);
    s_valid_i = 1'b1;
    s_data_i = 16'h0043;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({s_ready_o, fifo_a_wr_o, fifo_b_wr_o, core_start_o, pixel_done_o, busy_o} !== 6'b0
        || error_code_o !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: ctrl %b code %h, required 000000 00",
               {s_ready_o, fifo_a_wr_o, fifo_b_wr_o, core_start_o, pixel_done_o, busy_o}, error_code_o);
    end
    tick();
    tick();
    rst_i = 1'b0;
    s_valid_i = 1'b0;
    tick();
    m = sb_mismatch();
    checks++;
    if (n_pd != 0 || m != 0) begin
      errors++;
      $display("FAIL midreset_partial: pixel_done %0d mismatches %0d, required 0 0", n_pd, m);
    end

    clear_counts();
    do_start(2);
    feed(4, 16'h50, 0);
    core_done_i = 1'b1;
    core_err_i = 8'h00;
    tick();
    core_done_i = 1'b0;
    tick();
    tick();
    m = sb_mismatch();
    checks++;
    if (m != 0) begin
      errors++;
      $display("FAIL midreset_rerun_scoreboard: %0d mismatches, required 0", m);
    end
    checks++;
    if (n_cs != 1 || cs_cyc - start_cyc != 5 || n_pd != 1 || pd_err !== 8'h00) begin
      errors++;
      $display("FAIL midreset_rerun_run: core_start %0d offset %0d pixel_done %0d code %h, required 1 5 1 00",
               n_cs, cs_cyc - start_cyc, n_pd, pd_err);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    num_bands_i = '0;
    s_valid_i = 1'b0;
    s_data_i = '0;
    fifo_a_full_i = 1'b0;
    fifo_b_full_i = 1'b0;
    core_done_i = 1'b0;
    core_err_i = '0;
    hs = 1'b0;
    clear_counts();
    test_reset();
    test_zero_bands();
    test_basic();
    test_b_full_stall();
    test_timeout();
    test_ignored_start();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/hsi_band_streamer.md
# hsi_band_streamer

Loader stage directly upstream of the HSI vector core. On a start pulse from the OBI control wrapper it moves `num_bands` interleaved element pairs from an input stream into the core's vector-A and vector-B input FIFOs, then launches the core. It waits for the core's completion and returns a one-cycle `pixel_done` pulse and a held error code to the wrapper. It guards against zero-band requests and a hung core (timeout).

## Interface
Parameters:
- DATA_WIDTH, 16: width of one spectral element.
- NUM_BANDS_WIDTH, 8: width of the band count.
- ERR_WIDTH, 8: width of the error code; must be ≥ 8.
- TIMEOUT_WIDTH, 16: width of the core-wait cycle counter.

Ports:
- Clock and reset: one clock `clk_i`; reset `rst_i` is asynchronous and active-high.
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- start_i  in  1  one-cycle start pulse from the wrapper.
- num_bands_i  in  NUM_BANDS_WIDTH  band count; sampled only on an accepted start.
- s_valid_i  in  1  input stream valid.
- s_data_i  in  DATA_WIDTH  input element. Order is A0,B0,A1,B1,…
- s_ready_o  out  1  input stream ready.
- fifo_a_wr_o  out  1  write strobe, vector-A FIFO.
- fifo_b_wr_o  out  1  write strobe, vector-B FIFO.
- fifo_wdata_o  out  DATA_WIDTH  write data shared by both FIFOs; equals s_data_i.
- fifo_a_full_i  in  1  vector-A FIFO full.
- fifo_b_full_i  in  1  vector-B FIFO full.
- core_start_o  out  1  one-cycle core launch pulse.
- core_done_i  in  1  core completion pulse.
- core_err_i  in  ERR_WIDTH  core error code; valid while core_done_i is high.
- pixel_done_o  out  1  one-cycle completion pulse to the wrapper.
- error_code_o  out  ERR_WIDTH  result code, held until the next accepted start.
- busy_o  out  1  high in any state other than IDLE.

## Operation
FSM states are IDLE, LOAD, WAIT_CORE and DONE.

- **IDLE**
  - start_i=1 and num_bands_i=0: go to DONE, set error_code_o=0x01 (ERR_ZERO_BANDS).
  - start_i=1 and num_bands_i≠0: latch nb=num_bands_i, set band_cnt=0, sel=A, clear error_code_o to 0, go to LOAD.
- **LOAD**
  - s_ready_o = (sel==A) ? !fifo_a_full_i : !fifo_b_full_i.
  - A handshake is s_valid_i & s_ready_o.
    - If sel==A: assert fifo_a_wr_o.
    - If sel==B: assert fifo_b_wr_o.
    - Then toggle sel.
  - A handshake with sel==B increments band_cnt.
  - A handshake with sel==B and band_cnt==nb-1 moves to WAIT_CORE.
  - No timeout applies in LOAD.
- **WAIT_CORE**
  - The timeout counter is cleared on entry and increments on every cycle without core_done_i.
  - core_done_i=1: latch error_code_o=core_err_i, go to DONE.
  - Counter at all-ones and core_done_i=0: set error_code_o=0xFF (ERR_TIMEOUT), go to DONE.
  - core_done_i and the timeout in the same cycle: done wins, core_err_i is latched.
- **DONE**
  - pixel_done_o=1 for exactly this one cycle.
  - Next state is always IDLE.

General rules:
- start_i outside IDLE is ignored. It is not queued and error_code_o is unchanged.
- s_ready_o=0 and both FIFO strobes are 0 outside LOAD.
- The FIFO write strobes are never asserted together.
- band_cnt is NUM_BANDS_WIDTH wide. nb=2^NUM_BANDS_WIDTH-1 is legal; there is no wrap before completion.
- Reset mid-operation returns to IDLE immediately, discards the partial load and raises no pulse. FIFO flushing is the core's responsibility.

## Timing
Reset values:
- Internal state: IDLE; band_cnt=0; sel=A; timeout counter=0.
- Outputs: s_ready_o=0, fifo_a_wr_o=0, fifo_b_wr_o=0, fifo_wdata_o=s_data_i (combinational), core_start_o=0, pixel_done_o=0, error_code_o=0, busy_o=0.

Output timing:
- s_ready_o, fifo_*_wr_o and fifo_wdata_o are combinational from the state, sel, the full flags and s_valid_i.
- fifo_wdata_o follows s_data_i; it is meaningful only when a write strobe is high.
- core_start_o, pixel_done_o and busy_o are decoded from registered state. error_code_o is a register.

Cycle-level sequence:
- Start accepted at edge k: busy_o=1 and LOAD from cycle k+1.
- Last B handshake at edge m: WAIT_CORE from m+1, with core_start_o=1 during cycle m+1 only.
- core_done_i is sampled in every WAIT_CORE cycle, including the core_start_o cycle.
- core_done_i sampled at edge d: DONE during cycle d+1 (pixel_done_o=1, error_code_o valid); IDLE at d+2.
- A new start is accepted in the IDLE cycle d+2 at the earliest.

Throughput and latency:
- LOAD sustains one element per cycle with continuous valid and no full flags.
- Best-case start to core_start_o: 2·nb+1 cycles.
- Zero-band start at edge k: DONE in cycle k+1 with code 0x01; core_start_o is never asserted.
- Timeout fires after 2^TIMEOUT_WIDTH-1 consecutive WAIT_CORE cycles without done.

## Test plan
- nb=4, continuous valid, data 0x0001..0x0008 → A FIFO gets 1,3,5,7; B FIFO gets 2,4,6,8; core_start_o pulses once 9 cycles after start; core_done_i with core_err_i=0x00 → one pixel_done_o, error_code_o=0x00.
- nb=3, fifo_b_full_i held high for 5 cycles while sel==B → s_ready_o=0, no strobes, no lost or duplicated element; 3 A and 3 B writes total.
- num_bands_i=0 start → pixel_done_o one cycle later, error_code_o=0x01, core_start_o never asserted, no FIFO writes.
- TIMEOUT_WIDTH=4, no core_done_i → pixel_done_o 15 WAIT_CORE cycles after core_start_o, error_code_o=0xFF. Repeat with core_done_i (core_err_i=0x05) on the timeout cycle → error_code_o=0x05.
- start_i pulsed during LOAD and during WAIT_CORE → ignored; band count unaffected; exactly one pixel_done_o.
- rst_i asserted mid-LOAD after 3 elements → immediate IDLE, all outputs at reset values, no pixel_done_o; a fresh nb=2 run afterwards completes normally with A/B alternation starting at A.
